// File: rtl/hdmi_img_binarize.sv
// hdmi_img_binarize: follows the incoming video timing, fetches a picture
// window from a one-cycle-latency image ROM and renders each pixel as the
// original colour, gray, binary or inverted binary.
//
// The block has four register stages. For inputs sampled at clock edge t:
//   edge t   : ROM address, window flag and syncs are registered
//   edge t+1 : the ROM samples the address, the control flags move along
//   edge t+2 : luma and the raw RGB are registered
//   edge t+3 : rgb_out and the sync outputs are registered
// vs_out/hs_out/de_out therefore change at the edge that comes three edges
// after the edge that sampled vs_in/hs_in/de_in.

module hdmi_img_binarize #(
    parameter int          IMG_W      = 256,
    parameter int          IMG_H      = 256,
    parameter int          X_OFS      = 0,
    parameter int          Y_OFS      = 0,
    parameter int          ADDR_WIDTH = 16,
    parameter logic [7:0]  THRESH_DEF = 8'd128,
    parameter logic [23:0] BG_COLOR   = 24'h000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vs_in,
    input  logic                  hs_in,
    input  logic                  de_in,
    input  logic [7:0]            thresh,
    input  logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_data,
    output logic                  vs_out,
    output logic                  hs_out,
    output logic                  de_out,
    output logic [23:0]           rgb_out
);

    localparam int          CW   = 16;
    localparam logic [31:0] X_LO = 32'(X_OFS);
    localparam logic [31:0] X_HI = 32'(X_OFS + IMG_W);
    localparam logic [31:0] Y_LO = 32'(Y_OFS);
    localparam logic [31:0] Y_HI = 32'(Y_OFS + IMG_H);

    // Front-end state: edge detectors, counters and the per-frame settings
    logic                  vsPrev_q;
    logic                  dePrev_q;
    logic [CW-1:0]         x_q, x_d;
    logic [CW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] addrCnt_q, addrCnt_d;
    logic [ADDR_WIDTH-1:0] romAddr_q, romAddr_d;
    logic [7:0]            thr_q, thr_d;
    logic [1:0]            mode_q, mode_d;

    // Pipeline state; sync vectors are packed as {vs, hs, de}
    logic                  win1_q, win2_q, win3_q;
    logic [2:0]            sync1_q, sync2_q, sync3_q, syncOut_q;
    logic [7:0]            gray_q, gray_d;
    logic [23:0]           rgbRaw_q;
    logic [23:0]           rgbOut_q, rgbOut_d;

    // Combinational helpers
    logic                  vsRise;
    logic                  deFall;
    logic                  inWin;
    logic [CW-1:0]         xCur, yCur;
    logic [ADDR_WIDTH-1:0] addrCur;
    logic [15:0]           lumaSum;
    logic [23:0]           binPx;
    logic [23:0]           rendered;

    // A vs_in rising edge clears the counters before the current pixel uses
    // them, so a pixel that coincides with the edge is column 0 of line 0.
    always_comb begin
        vsRise    = vs_in & ~vsPrev_q;
        deFall    = dePrev_q & ~de_in;
        xCur      = vsRise ? '0 : x_q;
        yCur      = vsRise ? '0 : y_q;
        addrCur   = vsRise ? '0 : addrCnt_q;
        inWin     = de_in
                    & ({16'd0, xCur} >= X_LO) & ({16'd0, xCur} < X_HI)
                    & ({16'd0, yCur} >= Y_LO) & ({16'd0, yCur} < Y_HI);
        x_d       = de_in ? xCur + CW'(1) : '0;
        y_d       = vsRise ? '0 : (deFall ? y_q + CW'(1) : y_q);
        addrCnt_d = inWin ? addrCur + ADDR_WIDTH'(1) : addrCur;
        romAddr_d = inWin ? addrCur : romAddr_q;
        thr_d     = vsRise ? thresh : thr_q;
        mode_d    = vsRise ? mode : mode_q;
    end

    // Register the counters, the ROM address and the frame-start settings
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsPrev_q  <= 1'b0;
            dePrev_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            addrCnt_q <= '0;
            romAddr_q <= '0;
            thr_q     <= THRESH_DEF;
            mode_q    <= 2'd2;
        end else begin
            vsPrev_q  <= vs_in;
            dePrev_q  <= de_in;
            x_q       <= x_d;
            y_q       <= y_d;
            addrCnt_q <= addrCnt_d;
            romAddr_q <= romAddr_d;
            thr_q     <= thr_d;
            mode_q    <= mode_d;
        end
    end

    // Luma from the ROM word; the 16-bit sum peaks at 65280 so it never wraps
    always_comb begin
        lumaSum = ({8'd0, rom_data[23:16]} * 16'd77)
                + ({8'd0, rom_data[15:8]}  * 16'd150)
                + ({8'd0, rom_data[7:0]}   * 16'd29);
        gray_d  = 8'(lumaSum >> 8);
    end

    // Carry window and sync flags alongside the ROM access and luma stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win1_q   <= 1'b0;
            win2_q   <= 1'b0;
            win3_q   <= 1'b0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            sync3_q  <= '0;
            gray_q   <= '0;
            rgbRaw_q <= '0;
        end else begin
            win1_q   <= inWin;
            win2_q   <= win1_q;
            win3_q   <= win2_q;
            sync1_q  <= {vs_in, hs_in, de_in};
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            gray_q   <= gray_d;
            rgbRaw_q <= rom_data;
        end
    end

    // Pick the rendering for the pixel, then blank or background it
    always_comb begin
        binPx = (gray_q >= thr_q) ? 24'hFFFFFF : 24'h000000;
        case (mode_q)
            2'd0:    rendered = rgbRaw_q;
            2'd1:    rendered = {gray_q, gray_q, gray_q};
            2'd2:    rendered = binPx;
            default: rendered = ~binPx;
        endcase
        if (!sync3_q[0]) begin
            rgbOut_d = 24'h000000;
        end else if (!win3_q) begin
            rgbOut_d = BG_COLOR;
        end else begin
            rgbOut_d = rendered;
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syncOut_q <= '0;
            rgbOut_q  <= '0;
        end else begin
            syncOut_q <= sync3_q;
            rgbOut_q  <= rgbOut_d;
        end
    end

    assign rom_addr = romAddr_q;
    assign vs_out   = syncOut_q[2];
    assign hs_out   = syncOut_q[1];
    assign de_out   = syncOut_q[0];
    assign rgb_out  = rgbOut_q;

endmodule

// File: tb/tb_hdmi_img_binarize.sv
// Testbench for hdmi_img_binarize: drives whole video frames, models the
// expected picture per pixel from frame geometry, and checks every cycle.

module tb_hdmi_img_binarize;

    localparam int          IMG_W = 4;
    localparam int          IMG_H = 2;
    localparam int          X_OFS = 2;
    localparam int          Y_OFS = 1;
    localparam logic [23:0] BG    = 24'h2040C0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs_in, hs_in, de_in;
    logic [7:0]  thresh;
    logic [1:0]  mode;
    logic [15:0] rom_addr;
    logic [23:0] rom_data;
    logic        vs_out, hs_out, de_out;
    logic [23:0] rgb_out;

    hdmi_img_binarize #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .X_OFS(X_OFS), .Y_OFS(Y_OFS),
        .ADDR_WIDTH(16), .THRESH_DEF(8'd128), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
        .thresh(thresh), .mode(mode), .rom_addr(rom_addr), .rom_data(rom_data),
        .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    // Image ROM with one clock of read latency
    logic [23:0] romMem [256];
    always @(posedge clk) rom_data <= romMem[rom_addr[7:0]];

    typedef struct {
        logic [2:0]  sync;
        logic [23:0] rgb;
        bit          chkRgb;
        bit          addrChk;
        logic [15:0] addr;
        bit          litChk;
        logic [23:0] litRgb;
    } expT;

    expT         expQ[$];
    int          nChecks = 0;
    int          nFails  = 0;

    // Model state: settings latched at frame start and window pixel count
    logic [7:0]  mThr;
    logic [1:0]  mMode;
    bit          mVsPrev;
    int          mWinCnt;

    // Hand-computed literal pictures for the first eight window pixels
    logic [23:0] litTab [8];
    bit          litOn = 1'b0;

    function automatic logic [23:0] renderModel(logic [23:0] px, logic [1:0] md, logic [7:0] th);
        int          g;
        logic [23:0] b;
        g = (77 * int'(px[23:16]) + 150 * int'(px[15:8]) + 29 * int'(px[7:0])) / 256;
        b = (g >= int'(th)) ? 24'hFFFFFF : 24'h000000;
        case (md)
            2'd0:    return px;
            2'd1:    return {3{8'(g)}};
            2'd2:    return b;
            default: return ~b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // One pixel clock of stimulus; line/col are the active-area coordinates
    task automatic applyStimulus(input bit rstN, input bit vsI, input bit hsI, input bit deI,
                                 input int line, input int col, input bit rgbOk);
        expT e;
        expT t;
        bit  win;
        @(posedge clk);
        #1;
        rst_n = rstN;
        vs_in = vsI;
        hs_in = hsI;
        de_in = deI;
        e = '{sync: 3'b000, rgb: 24'h0, chkRgb: 1'b1, addrChk: 1'b0,
              addr: 16'h0, litChk: 1'b0, litRgb: 24'h0};
        if (!rstN) begin
            // A reset flushes the three pixels already inside the pipeline
            for (int i = expQ.size() - 3; i < expQ.size(); i++) begin
                if (i >= 0) begin
                    t        = expQ[i];
                    t.sync   = 3'b000;
                    t.rgb    = 24'h0;
                    t.chkRgb = 1'b1;
                    t.litChk = 1'b0;
                    expQ[i]  = t;
                end
            end
            e.addrChk = 1'b1;
            mThr      = 8'd128;
            mMode     = 2'd2;
            mVsPrev   = 1'b0;
            mWinCnt   = 0;
            expQ.push_back(e);
            return;
        end
        if (vsI && !mVsPrev) begin
            mThr    = thresh;
            mMode   = mode;
            mWinCnt = 0;
        end
        mVsPrev = vsI;
        win = deI && col >= X_OFS && col < X_OFS + IMG_W && line >= Y_OFS && line < Y_OFS + IMG_H;
        e.sync   = {vsI, hsI, deI};
        e.chkRgb = rgbOk;
        if (win) begin
            e.addrChk = rgbOk;
            e.addr    = 16'(mWinCnt);
            e.rgb     = renderModel(romMem[mWinCnt % 256], mMode, mThr);
            if (litOn && rgbOk && mWinCnt < 8) begin
                e.litChk = 1'b1;
                e.litRgb = litTab[mWinCnt];
            end
            mWinCnt++;
        end else if (deI) begin
            e.rgb = BG;
        end
        expQ.push_back(e);
    endtask

    // Address is due one edge after sampling, pixel and syncs four edges after
    always @(negedge clk) begin
        expT e;
        if (expQ.size() >= 2) begin
            e = expQ[expQ.size() - 2];
            if (e.addrChk) checkOutput("rom_addr", {8'h0, rom_addr}, {8'h0, e.addr});
        end
        if (expQ.size() >= 5) begin
            e = expQ.pop_front();
            checkOutput("syncs", {21'h0, vs_out, hs_out, de_out}, {21'h0, e.sync});
            if (e.chkRgb) checkOutput("rgb_out", rgb_out, e.rgb);
            if (e.litChk) checkOutput("rgb_literal", rgb_out, e.litRgb);
        end
    end

    // One frame: optional vs leading the active area, optional reset pulse
    task automatic runFrame(input int actW, input int actH, input bit vsOnDe,
                            input logic [7:0] thrA, input logic [1:0] modeA,
                            input logic [7:0] thrB, input logic [1:0] modeB,
                            input int rstLine, input int rstCol);
        bit ok = 1'b1;
        bit r;
        thresh = thrA;
        mode   = modeA;
        if (!vsOnDe) begin
            repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, -1, -1, ok);
            repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, ok);
        end
        for (int l = 0; l < actH; l++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, -1, -1, ok);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, ok);
            for (int c = 0; c < actW; c++) begin
                r = (l == rstLine && c == rstCol);
                if (r) ok = 1'b0;
                applyStimulus(!r, vsOnDe && l == 0 && c < 2, 1'b0, 1'b1, l, c, ok);
            end
            repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, ok);
            thresh = thrB;
            mode   = modeB;
        end
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, ok);
    endtask

    task automatic setLit(input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2,
                          input logic [23:0] a3, input logic [23:0] a4, input logic [23:0] a5,
                          input logic [23:0] a6, input logic [23:0] a7);
        litTab[0] = a0; litTab[1] = a1; litTab[2] = a2; litTab[3] = a3;
        litTab[4] = a4; litTab[5] = a5; litTab[6] = a6; litTab[7] = a7;
    endtask

    initial begin
        rst_n  = 1'b0;
        vs_in  = 1'b0;
        hs_in  = 1'b0;
        de_in  = 1'b0;
        thresh = 8'd0;
        mode   = 2'd0;
        foreach (romMem[i]) romMem[i] = 24'h0;
        romMem[0] = 24'h808080; romMem[1] = 24'h7F7F7F;
        romMem[2] = 24'hFF0000; romMem[3] = 24'hFFFFFF;
        romMem[4] = 24'h000000; romMem[5] = 24'h818181;
        romMem[6] = 24'h010101; romMem[7] = 24'h00FF00;

        // Reset held for five clocks under random inputs, then quiet idle
        for (int i = 0; i < 5; i++) begin
            thresh = 8'($urandom);
            mode   = 2'($urandom);
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), -1, -1, 1'b1);
        end
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1);

        litOn = 1'b1;
        // Binary, threshold 128: address walk and luma threshold cases
        setLit(24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF,
               24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF);
        runFrame(8, 4, 1'b0, 8'd128, 2'd2, 8'd128, 2'd2, -1, -1);
        // Gray
        setLit(24'h808080, 24'h7F7F7F, 24'h4C4C4C, 24'hFFFFFF,
               24'h000000, 24'h818181, 24'h010101, 24'h959595);
        runFrame(8, 4, 1'b0, 8'd128, 2'd1, 8'd128, 2'd1, -1, -1);
        // Original colour
        setLit(24'h808080, 24'h7F7F7F, 24'hFF0000, 24'hFFFFFF,
               24'h000000, 24'h818181, 24'h010101, 24'h00FF00);
        runFrame(8, 4, 1'b0, 8'd128, 2'd0, 8'd128, 2'd0, -1, -1);
        // Inverted binary
        setLit(24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000,
               24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000);
        runFrame(8, 4, 1'b0, 8'd128, 2'd3, 8'd128, 2'd3, -1, -1);
        // Settings changed mid-frame must wait for the next frame
        setLit(24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF,
               24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF);
        runFrame(8, 4, 1'b0, 8'd128, 2'd2, 8'd200, 2'd3, -1, -1);
        setLit(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000,
               24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        runFrame(8, 4, 1'b0, 8'd200, 2'd3, 8'd200, 2'd3, -1, -1);
        // One-clock reset at line 1, column 3, then a clean frame
        setLit(24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF,
               24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF);
        runFrame(8, 4, 1'b0, 8'd128, 2'd2, 8'd128, 2'd2, 1, 3);
        runFrame(8, 4, 1'b0, 8'd128, 2'd2, 8'd128, 2'd2, -1, -1);
        // vs rising together with the first active pixel
        runFrame(8, 4, 1'b1, 8'd128, 2'd2, 8'd128, 2'd2, -1, -1);
        litOn = 1'b0;

        // Random frames, including ones smaller than the window
        for (int f = 0; f < 24; f++) begin
            foreach (romMem[i]) romMem[i] = 24'($urandom);
            runFrame(int'($urandom_range(10, 1)), int'($urandom_range(5, 1)), 1'($urandom),
                     8'($urandom), 2'($urandom), 8'($urandom), 2'($urandom), -1, -1);
        end

        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hdmi_img_binarize.md
# hdmi_img_binarize

Downstream consumer of the 24-bit image ROM (16-bit address, one-clock read latency) in the HDMI picture-binarization demo. The block:
- follows the incoming video timing and generates row-major ROM addresses for a picture window placed inside the active area;
- converts each fetched RGB888 pixel to 8-bit luma and renders it as original, gray, binary or inverted-binary;
- delays the sync/DE signals to match, and feeds the HDMI transmitter.

## Interface
Parameters:
- IMG_W, 256, picture width in pixels
- IMG_H, 256, picture height in lines
- X_OFS, 0, first active column of the window
- Y_OFS, 0, first active line of the window
- ADDR_WIDTH, 16, ROM address width; IMG_W*IMG_H ≤ 2^ADDR_WIDTH
- THRESH_DEF, 8'd128, threshold loaded at reset
- BG_COLOR, 24'h000000, RGB driven for active pixels outside the window

Ports:
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- vs_in  in  1  vertical sync, active-high
- hs_in  in  1  horizontal sync, active-high
- de_in  in  1  data enable, active-high
- thresh  in  8  runtime binarization threshold
- mode  in  2  0 original, 1 gray, 2 binary, 3 inverted binary
- rom_addr  out  ADDR_WIDTH  registered ROM address
- rom_data  in  24  ROM read data {R[23:16],G[15:8],B[7:0]}, valid one clk after rom_addr
- vs_out, hs_out, de_out  out  1 each  syncs delayed by 3 clks
- rgb_out  out  24  output pixel

## Operation
- Column counter x:
  - +1 each clk with de_in=1;
  - cleared on the clk after de_in falls.
- Line counter y:
  - +1 on each de_in falling edge;
  - cleared on the vs_in rising edge.
- Window condition in_win: de_in & (X_OFS ≤ x < X_OFS+IMG_W) & (Y_OFS ≤ y < Y_OFS+IMG_H).
- Address counter:
  - cleared on the vs_in rising edge;
  - +1 on every in_win cycle, with natural wrap at 2^ADDR_WIDTH;
  - rom_addr is registered from the counter value on in_win cycles and holds its last value otherwise;
  - no multiplier.
- Frame-start latch: on the vs_in rising edge, register thresh→thr_r and mode→mode_r. Changes mid-frame have no effect until the next frame.
- Luma: gray = (77·R + 150·G + 29·B) >> 8.
  - 16-bit unsigned intermediate; the maximum 65280 cannot overflow.
  - Result is 8 bits, 0..255.
- Render:
  - mode_r 0 → rom_data delayed;
  - mode_r 1 → {gray,gray,gray};
  - mode_r 2 → gray ≥ thr_r ? FFFFFF : 000000;
  - mode_r 3 → the complement of mode 2.
- Pixel output:
  - in_win delayed 3 = 0 with de delayed = 1 → BG_COLOR;
  - de delayed = 0 → 000000.

## Timing
- Pipeline:
  - S1: edge t registers rom_addr, in_win, syncs;
  - ROM samples rom_addr at edge t+1;
  - S2: edge t+2 registers gray and the raw RGB;
  - S3: edge t+3 registers rgb_out and the syncs.
- Fixed latency of 3 clks from vs_in/hs_in/de_in to the corresponding outputs, for every pixel. No stalls, no handshake.
- Reset (rst_n=0 sampled at a clk edge) clears:
  - rom_addr=0, rgb_out=0, vs_out=hs_out=de_out=0;
  - x=y=0, address counter=0, all pipeline valid/sync bits=0;
  - thr_r=THRESH_DEF, mode_r=2.
- Reset mid-line or mid-frame: outputs stay 0 until the first de_in after release. Addressing is correct only from the next vs_in rising edge; the first partial frame may show a shifted picture.
- vs_in rising in the same clk as de_in=1: the counters clear first, so that pixel is x=0, y=0.
- Last window pixel: when IMG_W·IMG_H = 2^ADDR_WIDTH, the counter wraps to 0, which equals the frame-start value.
- Frames with fewer active lines/columns than the window: the unreached addresses are simply never issued; no error.

## Test plan
- Reset: hold rst_n=0 for 5 clks with random inputs → all outputs 0; after release with no de_in, outputs stay 0.
- Address walk (IMG_W=4, IMG_H=2, X_OFS=2, Y_OFS=1, 8×4 active frame):
  - rom_addr takes 0,1,2,3 on line 1, columns 2..5;
  - rom_addr takes 4,5,6,7 on line 2;
  - all other active pixels show BG_COLOR;
  - de_out lags de_in by exactly 3 clks.
- Luma/threshold, mode 2, thr=128:
  - rom_data 808080 → gray 128 → FFFFFF;
  - rom_data 7F7F7F → 127 → 000000;
  - rom_data FF0000 → gray 76 → 000000.
- Modes:
  - mode 1 with FF0000 → 4C4C4C;
  - mode 0 → FF0000;
  - mode 3 with 808080 → 000000.
- Frame latch: change thresh 128→200 and mode 2→3 mid-frame → the current frame is unchanged; the new values apply from the first pixel after the next vs_in rise.
- Reset mid-frame: pulse rst_n=0 for 1 clk at line 1, column 3 → outputs 0 for that clk+pipeline; after the next vs_in, rom_addr restarts at 0 and the pixel stream is correct.
